// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and transmit-arbiter state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_GAP   = 2'd2
   } uart_arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority picker: first asserted req at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
//
// Ports:
//   req  in  N  request vector
//   ptr  in  W  index with highest priority this cycle
//   hit  out 1  at least one request asserted
//   idx  out W  winning index (0 when no hit)
module uart_rr_pick
   import uart_pkg::*;
#(
   parameter  int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         hit,
   output logic [W-1:0] idx
);

   // Walk offsets from the farthest to the nearest so the nearest candidate
   // (lowest offset from ptr) is the last to overwrite the result.
   always_comb begin
      int c;
      hit = 1'b0;
      idx = '0;
      c   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         c = (int'(ptr) + k) % N;
         if (req[c]) begin
            hit = 1'b1;
            idx = W'(c);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmitter between N_REQ byte streams.
// Latency: grant one cycle after a request is seen in IDLE; bytes pass through combinationally.
// Backpressure: uart_ready is forwarded only to the granted requester; all others see ready low.
//
// Ports:
//   clk, rst               clock; synchronous active-low reset
//   req_valid/data/last    per-requester byte streams (requester i at data[i*DATA_BITS +: DATA_BITS])
//   req_ready              per-requester accept
//   uart_valid/data/ready  handshake towards the UART transmit input
//   grant_id               current or most recent grantee
//   busy                   high while in GRANT or GAP
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter  int N_REQ      = 4,
   parameter  int DATA_BITS  = UART_DATA_BITS,
   parameter  int MAX_BURST  = 64,
   parameter  int GAP_CYCLES = 0,
   localparam int GW         = $clog2(N_REQ),
   localparam int BW         = $clog2(MAX_BURST + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*DATA_BITS-1:0] req_data,
   input  logic [N_REQ-1:0]           req_last,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       uart_valid,
   output logic [DATA_BITS-1:0]       uart_data,
   input  logic                       uart_ready,
   output logic [GW-1:0]              grant_id,
   output logic                       busy
);

   uart_arb_state_t state_q;
   logic [GW-1:0]   grant_q;
   logic [GW-1:0]   rr_ptr_q;
   logic [GW-1:0]   rr_ptr_d;
   logic [BW-1:0]   burst_q;
   logic [7:0]      gap_q;
   logic            busy_q;

   logic                 pick_hit;
   logic [GW-1:0]        pick_idx;
   logic                 in_grant;
   logic                 sel_vld;
   logic                 sel_last;
   logic [DATA_BITS-1:0] sel_data;
   logic                 xfer;
   logic                 release_now;

   uart_rr_pick #(
      .N   (N_REQ)
   ) u_pick (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .hit (pick_hit),
      .idx (pick_idx)
   );

   assign in_grant = (state_q == ARB_GRANT);
   assign sel_vld  = req_valid[grant_q];
   assign sel_last = req_last[grant_q];
   assign sel_data = req_data[int'(grant_q)*DATA_BITS +: DATA_BITS];

   // Zero-latency passthrough while granted; everything quiet otherwise.
   always_comb begin
      uart_valid = in_grant & sel_vld;
      uart_data  = in_grant ? sel_data : '0;
      req_ready  = '0;
      if (in_grant) begin
         req_ready[grant_q] = uart_ready;
      end
   end

   assign xfer = uart_valid & uart_ready;

   // last and the burst limit on the same byte are one release: rr_ptr moves once.
   assign release_now = xfer & (sel_last | (burst_q == BW'(MAX_BURST - 1)));

   assign rr_ptr_d = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ARB_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         burst_q  <= '0;
         gap_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_hit) begin
                  grant_q <= pick_idx;
                  burst_q <= '0;
                  state_q <= ARB_GRANT;
                  busy_q  <= 1'b1;
               end
            end
            ARB_GRANT: begin
               if (xfer) begin
                  burst_q <= burst_q + BW'(1);
               end
               if (release_now) begin
                  rr_ptr_q <= rr_ptr_d;
                  if (GAP_CYCLES > 0) begin
                     state_q <= ARB_GAP;
                     gap_q   <= 8'(GAP_CYCLES - 1);
                  end else begin
                     state_q <= ARB_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            ARB_GAP: begin
               if (gap_q == 8'd0) begin
                  state_q <= ARB_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  gap_q <= gap_q - 8'd1;
               end
            end
            default: begin
               state_q <= ARB_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign grant_id = grant_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: three instances (default, MAX_BURST=3, GAP_CYCLES=4)
// share one set of requester inputs; the one under test is selected by cur.
// Transfers are checked against an expected-order scoreboard; corner cases use hand sequences.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DB = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_last;
   logic [N*DB-1:0] req_data;
   logic            uart_ready;

   logic [N-1:0]    rdy_o  [3];
   logic            uv_o   [3];
   logic [DB-1:0]   ud_o   [3];
   logic [1:0]      gid_o  [3];
   logic            busy_o [3];

   int cur = 0;

   logic [N-1:0]  m_rdy;
   logic          m_uv;
   logic [DB-1:0] m_ud;
   logic [1:0]    m_gid;
   logic          m_busy;

   assign m_rdy  = rdy_o[cur];
   assign m_uv   = uv_o[cur];
   assign m_ud   = ud_o[cur];
   assign m_gid  = gid_o[cur];
   assign m_busy = busy_o[cur];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      uart_tx_arbiter #(
         .N_REQ      (N),
         .DATA_BITS  (DB),
         .MAX_BURST  (g == 1 ? 3 : 64),
         .GAP_CYCLES (g == 2 ? 4 : 0)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .req_valid  (req_valid),
         .req_data   (req_data),
         .req_last   (req_last),
         .req_ready  (rdy_o[g]),
         .uart_valid (uv_o[g]),
         .uart_data  (ud_o[g]),
         .uart_ready (uart_ready),
         .grant_id   (gid_o[g]),
         .busy       (busy_o[g])
      );
   end

   // Requester model: per-requester byte memory {last, data} with read/write counts.
   logic [8:0] mem [N][16];
   int         wr_n [N];
   int         rd_n [N];

   typedef struct {
      int gid;
      int dat;
   } exp_t;
   exp_t exp_q[$];
   int   xlog[$];
   int   cyc = 0;

   typedef struct {
      int       pre;
      logic [3:0] vld;
      int       exp_gid;
   } vec_t;
   vec_t vecs[7];

   int n_err = 0;
   int n_chk = 0;

   task automatic chk(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic load(input int i, input logic [7:0] d, input logic last);
      mem[i][wr_n[i]] = {last, d};
      wr_n[i]++;
   endtask

   task automatic expect_x(input int i, input int d);
      exp_q.push_back('{i, d});
   endtask

   task automatic update_drv();
      for (int i = 0; i < N; i++) begin
         if (rd_n[i] < wr_n[i]) begin
            req_valid[i]         = 1'b1;
            req_last[i]          = mem[i][rd_n[i]][8];
            req_data[i*DB +: DB] = mem[i][rd_n[i]][7:0];
         end else begin
            req_valid[i]         = 1'b0;
            req_last[i]          = 1'b0;
            req_data[i*DB +: DB] = '0;
         end
      end
   endtask

   task automatic check_xfer();
      exp_t e;
      xlog.push_back(cyc);
      if (exp_q.size() == 0) begin
         chk("xfer_unexpected", int'(m_gid), -1);
      end else begin
         e = exp_q.pop_front();
         chk("xfer_gid", int'(m_gid), e.gid);
         chk("xfer_data", int'(m_ud), e.dat);
      end
   endtask

   // One clock: sample handshakes away from the edge, then update drivers after it.
   task automatic cycle();
      logic [N-1:0] hs;
      @(negedge clk);
      hs = req_valid & m_rdy;
      if (m_uv && uart_ready) check_xfer();
      cyc++;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) rd_n[i]++;
      end
      update_drv();
   endtask

   task automatic run_drain(input string nm, input int budget);
      int b;
      b = 0;
      while (exp_q.size() > 0 && b < budget) begin
         cycle();
         b++;
      end
      chk({nm, "_drain"}, exp_q.size(), 0);
   endtask

   task automatic do_reset(input int inst);
      cur = inst;
      for (int i = 0; i < N; i++) begin
         rd_n[i] = 0;
         wr_n[i] = 0;
      end
      exp_q.delete();
      update_drv();
      uart_ready = 1'b1;
      rst = 1'b0;
      cycle();
      cycle();
      rst = 1'b1;
   endtask

   initial begin
      int   n0;
      logic stall;
      logic [7:0] sd;
      int   rr_ids [3];

      vecs[0] = '{-1, 4'b1010, 1};
      vecs[1] = '{-1, 4'b1111, 0};
      vecs[2] = '{ 1, 4'b0011, 0};
      vecs[3] = '{ 2, 4'b1001, 3};
      vecs[4] = '{ 3, 4'b1110, 1};
      vecs[5] = '{ 0, 4'b0001, 0};
      vecs[6] = '{ 1, 4'b0110, 2};
      rr_ids  = '{0, 1, 3};

      rst        = 1'b0;
      uart_ready = 1'b1;
      req_valid  = '0;
      req_last   = '0;
      req_data   = '0;

      // Reset values on every instance.
      do_reset(0);
      for (int g = 0; g < 3; g++) begin
         chk("rst_uart_valid", int'(uv_o[g]), 0);
         chk("rst_uart_data", int'(ud_o[g]), 0);
         chk("rst_req_ready", int'(rdy_o[g]), 0);
         chk("rst_grant_id", int'(gid_o[g]), 0);
         chk("rst_busy", int'(busy_o[g]), 0);
      end

      // Arbitration table: optional prior message sets rr_ptr, then a request pattern is applied
      // with uart_ready low so the grant can be inspected without a transfer.
      for (int v = 0; v < 7; v++) begin
         do_reset(0);
         if (vecs[v].pre >= 0) begin
            load(vecs[v].pre, 8'(16 + vecs[v].pre), 1'b1);
            expect_x(vecs[v].pre, 16 + vecs[v].pre);
            update_drv();
            run_drain("vec_pre", 10);
         end
         uart_ready = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (vecs[v].vld[i]) load(i, 8'(8'h80 + i), 1'b1);
         end
         update_drv();
         cycle();
         chk("vec_gid", int'(m_gid), vecs[v].exp_gid);
         chk("vec_busy", int'(m_busy), 1);
         chk("vec_uart_valid", int'(m_uv), 1);
         chk("vec_req_ready", int'(m_rdy), 0);
         chk("vec_uart_data", int'(m_ud), 8'h80 + vecs[v].exp_gid);
      end

      // Single requester, two-byte message.
      do_reset(0);
      load(2, 8'h41, 1'b0);
      load(2, 8'h42, 1'b1);
      expect_x(2, 8'h41);
      expect_x(2, 8'h42);
      update_drv();
      cycle();
      chk("single_gid", int'(m_gid), 2);
      chk("single_busy", int'(m_busy), 1);
      chk("single_uart_valid", int'(m_uv), 1);
      chk("single_req_ready", int'(m_rdy), 4'b0100);
      chk("single_data0", int'(m_ud), 8'h41);
      run_drain("single", 10);
      cycle();
      chk("single_busy_after", int'(m_busy), 0);
      chk("single_valid_after", int'(m_uv), 0);
      // rr_ptr is now 3: req 3 beats req 0.
      load(0, 8'h01, 1'b1);
      load(3, 8'h03, 1'b1);
      expect_x(3, 8'h03);
      expect_x(0, 8'h01);
      update_drv();
      run_drain("single_ptr", 10);

      // Round-robin over 0, 1, 3 with continuous one-byte messages.
      do_reset(0);
      for (int m = 0; m < 2; m++) begin
         for (int k = 0; k < 3; k++) begin
            load(rr_ids[k], 8'(16 * rr_ids[k] + m), 1'b1);
            expect_x(rr_ids[k], 16 * rr_ids[k] + m);
         end
      end
      update_drv();
      n0 = xlog.size();
      run_drain("rr", 30);
      chk("rr_count", xlog.size() - n0, 6);
      for (int k = n0 + 1; k < xlog.size(); k++) begin
         chk("rr_spacing", xlog[k] - xlog[k-1], 2);
      end

      // Backpressure: uart_ready 1010 during a 4-byte message from req 1.
      do_reset(0);
      for (int i = 0; i < 4; i++) begin
         load(1, 8'(8'hC0 + i), (i == 3));
         expect_x(1, 8'hC0 + i);
      end
      update_drv();
      n0 = xlog.size();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         uart_ready = (i % 2 == 0);
         #1;
         stall = m_uv & ~uart_ready;
         sd    = m_ud;
         cycle();
         if (stall) begin
            chk("bp_hold_valid", int'(m_uv), 1);
            chk("bp_hold_data", int'(m_ud), int'(sd));
         end
      end
      chk("bp_drain", exp_q.size(), 0);
      uart_ready = 1'b1;
      for (int i = 0; i < 4; i++) cycle();
      chk("bp_count", xlog.size() - n0, 4);

      // Burst limit (MAX_BURST=3): req 0 streams 5 bytes without last, req 1 waits.
      do_reset(1);
      for (int i = 0; i < 5; i++) load(0, 8'(8'hD0 + i), 1'b0);
      load(1, 8'hE0, 1'b1);
      expect_x(0, 8'hD0);
      expect_x(0, 8'hD1);
      expect_x(0, 8'hD2);
      expect_x(1, 8'hE0);
      expect_x(0, 8'hD3);
      expect_x(0, 8'hD4);
      update_drv();
      run_drain("burst", 40);
      cycle();
      chk("burst_hold_gid", int'(m_gid), 0);
      chk("burst_hold_busy", int'(m_busy), 1);

      // Gap (GAP_CYCLES=4): back-to-back one-byte messages from req 0 and req 1.
      do_reset(2);
      load(0, 8'hF0, 1'b1);
      load(1, 8'hF1, 1'b1);
      expect_x(0, 8'hF0);
      expect_x(1, 8'hF1);
      update_drv();
      n0 = xlog.size();
      cycle();
      cycle();
      chk("gap_busy", int'(m_busy), 1);
      chk("gap_uart_valid", int'(m_uv), 0);
      chk("gap_req_ready", int'(m_rdy), 0);
      run_drain("gap", 20);
      chk("gap_count", xlog.size() - n0, 2);
      if (xlog.size() >= n0 + 2) chk("gap_spacing", xlog[n0+1] - xlog[n0], 6);

      // Reset during byte 2 of a 4-byte message from req 1, with rr_ptr previously at 1.
      do_reset(0);
      load(0, 8'h10, 1'b1);
      expect_x(0, 8'h10);
      update_drv();
      run_drain("mrst_pre", 10);
      for (int i = 0; i < 4; i++) load(1, 8'(8'hA0 + i), (i == 3));
      expect_x(1, 8'hA0);
      update_drv();
      cycle();
      cycle();
      chk("mrst_pre_gid", int'(m_gid), 1);
      uart_ready = 1'b0;
      rst        = 1'b0;
      cycle();
      chk("mrst_uart_valid", int'(m_uv), 0);
      chk("mrst_uart_data", int'(m_ud), 0);
      chk("mrst_req_ready", int'(m_rdy), 0);
      chk("mrst_grant_id", int'(m_gid), 0);
      chk("mrst_busy", int'(m_busy), 0);
      rst        = 1'b1;
      uart_ready = 1'b1;
      rd_n[1]    = 0;
      load(0, 8'h50, 1'b1);
      expect_x(0, 8'h50);
      for (int i = 0; i < 4; i++) expect_x(1, 8'hA0 + i);
      update_drv();
      run_drain("mrst", 30);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
